wallace_mult_pipe: RTL
======================

// Module: wallace_mult_pipe
// PURPOSE
//  Parametrised, pipelined Wallace-tree multiplier; next generation of the team's combinational 8x8 Wallace block.
//  Adds WIDTH generalisation, per-operation signed/unsigned mode, PIPE_STAGES register cuts in the CSA tree,
//  and valid/ready handshakes with back-pressure on both sides.
//  Sits between operand producers and any datapath consumer needing a full-width product each cycle.
// PARAMETERS
//  WIDTH        8  operand width in bits, >=4; product width is 2*WIDTH
//  PIPE_STAGES  2  register cuts inside the CSA reduction tree, 0..4; final CPA stage always registered
// PORTS
//  clk          in   1         rising-edge clock
//  rst          in   1         synchronous, active-high reset
//  in_valid     in   1         operand beat valid
//  in_ready     out  1         block accepts beat this cycle
//  a            in   WIDTH     multiplicand
//  b            in   WIDTH     multiplier
//  signed_mode  in   1         1: a, b two's complement; 0: unsigned; sampled with the beat
//  out_valid    out  1         product valid
//  out_ready    in   1         consumer accepts product this cycle
//  out          out  2*WIDTH   product (accumulated result when WMUL_ACC_EN is defined)
//  acc_clr      in   1         WMUL_ACC_EN only; sampled with the beat; restart accumulation from this product
// BEHAVIOUR
//  - Accept on (in_valid & in_ready) at a rising edge; output handoff on (out_valid & out_ready).
//  - N = PIPE_STAGES+1 register stages, each with its own valid bit v[k]; stage N-1 drives out/out_valid.
//  - Stage k loads when !v[k] or stage k+1 loads (last stage: when !out_valid or out_ready); bubbles collapse.
//  - in_ready = stage-0 load condition; combinational from out_ready through the valid chain only, never from in_valid.
//  - Latency: beat accepted at edge n shows out_valid=1 after edge n+N when not back-pressured (N=3 at defaults).
//  - Throughput: one beat per cycle while out_ready=1; N beats held in-flight under a stall; none lost or duplicated.
//  - While out_valid=1 & out_ready=0, out holds stable.
//  - Partial products: AND array; signed_mode=1 uses Baugh-Wooley (invert MSB-row/column terms, +1 at cols WIDTH and 2*WIDTH-1).
//  - Reduction: 3:2 / 2:2 CSA levels to two rows, then ripple or CLA final adder in the last stage.
//  - Result is the exact 2*WIDTH product, no truncation or saturation.
//  - signed_mode travels with its beat; mixing modes in consecutive beats is legal.
//  - Unsigned max: (2^W-1)^2 fits 2W bits.
//  - Signed (-2^(W-1))^2 = 2^(2W-2) is representable and positive.
//  - Reset: all v[k]=0, out_valid=0, out=0, pipeline data regs=0, in_ready=1 the cycle after rst deasserts.
//  - rst asserted mid-operation discards all in-flight beats; no output produced for them.
//  - rst dominates in_valid/out_ready in the same cycle.
//  - Inputs unqualified by in_valid are don't-care and must not change state.
// CONFIGURATION
//  WMUL_ACC_EN defined: multiply-accumulate.
//   - Register acc[2W-1:0] (reset 0) is updated when a beat leaves the last stage.
//   - acc_clr=1: out = product, acc <= product; else out = acc + product, acc <= same.
//   - Sum wraps modulo 2^(2W) in both modes.
//   - Accumulation follows output handoff order, so stalls do not alter results.
//  WMUL_ACC_EN undefined: acc_clr port and acc register absent; out = product of the beat only.
// TESTING
//  1 W=8, unsigned 255*255, out_ready=1 -> out=16'hFE01, out_valid exactly 3 cycles after accept.
//  2 W=8, signed -128*-128 -> 16'h4000; signed -1*1 -> 16'hFFFF; next beat unsigned 255*1 -> 16'h00FF.
//  3 Stream 6 beats (i*i, i=1..6), out_ready=0 for 5 cycles:
//    - in_ready falls after 3 beats held.
//    - After release: 1,4,9,16,25,36 in order, no gaps.
//  4 rst pulse 1 cycle with 2 beats in flight:
//    - next cycle out_valid=0, out=0, in_ready=1.
//    - Fresh 7*9 -> 63, and no stale result emerges.
//  5 Random 10k beats, random in_valid/out_ready, W=8 and W=16, PIPE_STAGES 0..4 -> matches a*b reference model.
//  6 WMUL_ACC_EN: 3*4 with acc_clr=1 -> 12, then 5*6 -> 42, then unsigned 255*255 with acc_clr=1 -> 16'hFE01.
//    - Next 1*255 -> 16'hFF00 (check wrap on further adds).

Source files
------------

// File: rtl/wallace_mult_pipe.sv
// rtl/wallace_mult_pipe.sv - pipelined Wallace-tree multiplier with valid/ready handshakes; optional MAC via WMUL_ACC_EN
module wallace_mult_pipe #(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out
`ifdef WMUL_ACC_EN
    ,
    input  logic               acc_clr
`endif
);

    // Number of 3:2 levels needed to bring r0 rows down to two.
    function automatic int num_levels(input int r0);
        int r;
        int n;
        r = r0;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (r > 2) begin
                r = r - r / 3;
                n++;
            end
        end
        return n;
    endfunction

    // Row count entering level l when starting from r0 rows.
    function automatic int rows_at(input int r0, input int l);
        int r;
        r = r0;
        for (int i = 0; i < 64; i++) begin
            if (i < l && r > 2) begin
                r = r - r / 3;
            end
        end
        return r;
    endfunction

    localparam int PW     = 2 * WIDTH;
    localparam int MAXR   = WIDTH + 1;           // WIDTH partial-product rows + Baugh-Wooley constant row
    localparam int N      = PIPE_STAGES + 1;
    localparam int LEVELS = num_levels(MAXR);

    typedef logic [MAXR-1:0][PW-1:0] rows_t;

    // AND-array partial products; signed mode inverts the terms where exactly one operand
    // index is the sign bit and adds the correction ones at columns WIDTH and 2*WIDTH-1.
    function automatic rows_t pp_rows(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                      input logic s);
        rows_t r;
        logic  bit_v;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                bit_v = x[j] & y[i];
                if (s && ((i == WIDTH - 1) != (j == WIDTH - 1))) begin
                    bit_v = ~bit_v;
                end
                r[i][i+j] = bit_v;
            end
        end
        if (s) begin
            r[WIDTH] = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
        end
        return r;
    endfunction

    // One Wallace level: each group of three rows becomes sum + shifted carry, leftovers pass through.
    function automatic rows_t csa_level(input rows_t x, input int r);
        rows_t y;
        int    g;
        y = '0;
        g = r / 3;
        for (int i = 0; 3 * i + 2 < MAXR; i++) begin
            if (i < g) begin
                y[2*i]   = x[3*i] ^ x[3*i+1] ^ x[3*i+2];
                y[2*i+1] = ((x[3*i] & x[3*i+1]) | (x[3*i] & x[3*i+2]) |
                            (x[3*i+1] & x[3*i+2])) << 1;
            end
        end
        for (int j = 0; j < 2; j++) begin
            if (j < r % 3) begin
                y[2*g+j] = x[3*g+j];
            end
        end
        return y;
    endfunction

    // Apply the levels [l0, l1) of the tree.
    function automatic rows_t reduce_range(input rows_t x, input int l0, input int l1);
        rows_t y;
        y = x;
        for (int l = 0; l < LEVELS; l++) begin
            if (l >= l0 && l < l1) begin
                y = csa_level(y, rows_at(MAXR, l));
            end
        end
        return y;
    endfunction

    // Final carry-propagate adder over the two surviving rows.
    function automatic logic [PW-1:0] cpa(input rows_t x);
        return x[0] + x[1];
    endfunction

    logic [N-1:0]  v_q, v_d, load;
    logic [PW-1:0] out_q, out_d;

    // Load enables ripple back from the consumer: a stage moves if any later stage has a hole.
    always_comb begin : p_load
        logic hole;
        hole = out_ready;
        load = '0;
        for (int k = N - 1; k >= 0; k--) begin
            hole    = hole || !v_q[k];
            load[k] = hole;
        end
        v_d    = v_q;
        if (load[0]) begin
            v_d[0] = in_valid;
        end
        for (int k = 1; k < N; k++) begin
            if (load[k]) begin
                v_d[k] = v_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_stage
        localparam int LO = (k * LEVELS) / N;
        localparam int HI = ((k + 1) * LEVELS) / N;

        rows_t src;
        logic  src_v;
`ifdef WMUL_ACC_EN
        logic  src_clr;
`endif

        if (k == 0) begin : g_src_in
            assign src     = pp_rows(a, b, signed_mode);
            assign src_v   = in_valid;
`ifdef WMUL_ACC_EN
            assign src_clr = acc_clr;
`endif
        end else begin : g_src_prev
            assign src     = g_stage[k-1].g_mid.rows_q;
            assign src_v   = v_q[k-1];
`ifdef WMUL_ACC_EN
            assign src_clr = g_stage[k-1].g_mid.clr_q;
`endif
        end

        if (k < N - 1) begin : g_mid
            rows_t rows_q, rows_d;
`ifdef WMUL_ACC_EN
            logic  clr_q, clr_d;
`endif

            // Carry-save rows advance only with a real beat, so bubbles leave data untouched.
            always_comb begin
                rows_d = rows_q;
`ifdef WMUL_ACC_EN
                clr_d  = clr_q;
`endif
                if (load[k] && src_v) begin
                    rows_d = reduce_range(src, LO, HI);
`ifdef WMUL_ACC_EN
                    clr_d  = src_clr;
`endif
                end
            end

            // Stage data register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rows_q <= '0;
`ifdef WMUL_ACC_EN
                    clr_q  <= 1'b0;
`endif
                end else begin
                    rows_q <= rows_d;
`ifdef WMUL_ACC_EN
                    clr_q  <= clr_d;
`endif
                end
            end
        end else begin : g_last
            logic [PW-1:0] prod;

            // Remaining tree levels plus the final adder feed the result register.
            always_comb begin
                prod  = cpa(reduce_range(src, LO, LEVELS));
                out_d = out_q;
                if (load[k] && src_v) begin
`ifdef WMUL_ACC_EN
                    // The result register doubles as the accumulator, so sums follow handoff order.
                    out_d = (src_clr ? '0 : out_q) + prod;
`else
                    out_d = prod;
`endif
                end
            end
        end
    end

    // Valid chain and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            out_q <= '0;
        end else begin
            v_q   <= v_d;
            out_q <= out_d;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v_q[N-1];
    assign out       = out_q;

endmodule
